// File: rtl/package_settings.sv
// package_settings: shared sample/timestamp widths and the pulse finder FSM state type.
package package_settings;
    localparam int SIZE_FILTER_DATA = 15;
    localparam int DW = SIZE_FILTER_DATA + 1;
    localparam int TS_WIDTH = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLD} pf_state_t;
endpackage

// File: rtl/peak_finder_parameters.sv
// peak_finder_parameters: default tuning values for pulse_peak_finder and a counter sizing helper.
package peak_finder_parameters;
    localparam int DEF_THRESHOLD = 100;
    localparam int DEF_HOLDOFF = 8;
    localparam int DEF_MAX_WIDTH = 64;
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/peak_record_reg.sv
// peak_record_reg: single-entry output record with valid/ready handshake and saturating drop counter.
module peak_record_reg
    import package_settings::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                emit_i,
    input  logic [DW-1:0]       amp_i,
    input  logic [TS_WIDTH-1:0] time_i,
    input  logic                overlong_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [DW-1:0]       amp_o,
    output logic [TS_WIDTH-1:0] time_o,
    output logic                overlong_o,
    output logic [7:0]          lost_o
);
    logic                valid_q, valid_d;
    logic [DW-1:0]       amp_q, amp_d;
    logic [TS_WIDTH-1:0] time_q, time_d;
    logic                over_q, over_d;
    logic [7:0]          lost_q, lost_d;
    logic                load, drop;

    // A consume on the same edge frees the slot, so a new record may replace it.
    always_comb begin
        load    = emit_i && (!valid_q || ready_i);
        drop    = emit_i && valid_q && !ready_i;
        valid_d = load || (valid_q && !ready_i);
        amp_d   = load ? amp_i : amp_q;
        time_d  = load ? time_i : time_q;
        over_d  = load ? overlong_i : over_q;
        lost_d  = (drop && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            amp_q   <= '0;
            time_q  <= '0;
            over_q  <= 1'b0;
            lost_q  <= '0;
        end else begin
            valid_q <= valid_d;
            amp_q   <= amp_d;
            time_q  <= time_d;
            over_q  <= over_d;
            lost_q  <= lost_d;
        end
    end

    assign valid_o    = valid_q;
    assign amp_o      = amp_q;
    assign time_o     = time_q;
    assign overlong_o = over_q;
    assign lost_o     = lost_q;
endmodule

// File: rtl/pulse_peak_finder.sv
// pulse_peak_finder: detects pulses above THRESHOLD and reports the peak amplitude and first peak time.
module pulse_peak_finder
    import package_settings::*;
    import peak_finder_parameters::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DW-1:0]       input_data,
    input  logic                peak_ready,
    output logic                peak_valid,
    output logic [DW-1:0]       peak_amplitude,
    output logic [TS_WIDTH-1:0] peak_time,
    output logic                peak_overlong,
    output logic [7:0]          lost_count
);
    localparam int WW = cnt_width(MAX_WIDTH);
    localparam int HW = cnt_width(HOLDOFF);
    localparam logic signed [DW-1:0] THR = DW'(THRESHOLD);
    localparam logic [WW-1:0] MAX_W = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] HOLD_N = HW'(HOLDOFF);

    pf_state_t             state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q, max_time_q, max_time_d;
    logic signed [DW-1:0]  max_q, max_d, sample;
    logic [WW-1:0]         width_q, width_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  above, emit, emit_over;

    assign sample = $signed(input_data);
    assign above  = sample > THR;

    // The emitted record uses the next-state max so an overlong report includes the final sample.
    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        max_time_d = max_time_q;
        width_d    = width_q;
        hold_d     = hold_q;
        emit       = 1'b0;
        emit_over  = 1'b0;
        case (state_q)
            ST_IDLE: if (above) begin
                state_d    = ST_ARMED;
                max_d      = sample;
                max_time_d = ts_q;
                width_d    = WW'(1);
            end
            ST_ARMED: if (!above) begin
                emit    = 1'b1;
                state_d = ST_HOLD;
                hold_d  = '0;
            end else begin
                if (sample > max_q) begin
                    max_d      = sample;
                    max_time_d = ts_q;
                end
                width_d = width_q + WW'(1);
                if (width_d >= MAX_W) begin
                    emit      = 1'b1;
                    emit_over = 1'b1;
                    state_d   = ST_HOLD;
                    hold_d    = '0;
                end
            end
            ST_HOLD: if (hold_q < HOLD_N) begin
                hold_d = hold_q + HW'(1);
            end else if (!above) begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            max_q      <= '0;
            max_time_q <= '0;
            width_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TS_WIDTH'(1);
            max_q      <= max_d;
            max_time_q <= max_time_d;
            width_q    <= width_d;
            hold_q     <= hold_d;
        end
    end

    peak_record_reg u_rec (
        .clk        (clk),
        .reset      (reset),
        .emit_i     (emit),
        .amp_i      (max_d),
        .time_i     (max_time_d),
        .overlong_i (emit_over),
        .ready_i    (peak_ready),
        .valid_o    (peak_valid),
        .amp_o      (peak_amplitude),
        .time_o     (peak_time),
        .overlong_o (peak_overlong),
        .lost_o     (lost_count)
    );
endmodule
